serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, with an IDLE/RUN/DONE controller.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    serial_fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= fa_cout;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB during the last bit
                        ovf   <= carry ^ fa_cout;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition on the WIDTH=8 instance with operands scrambled while it runs.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] full;
        int         lat;
        full  = {1'b0, x} + {1'b0, y};
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        lat = 0;
        while (!done && lat < W + 4) begin
            check_eq("sum_hold_run", sum, exp_sum);
            check_eq("cout_hold_run", cout, exp_cout);
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        check_eq("latency", lat, W);
        check_eq("sum", sum, full[W-1:0]);
        check_eq("cout", cout, full[W]);
        check_eq("busy_in_done", busy, 1);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf", ovf, (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]));
`endif
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        tick();
        check_eq("done_pulse_end", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("sum_hold_idle", sum, exp_sum);
    endtask

    task automatic run_add1(input logic x, input logic y);
        int lat;
        a1     = x;
        b1     = y;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 5) begin
            tick();
            lat++;
        end
        check_eq("w1_latency", lat, 1);
        check_eq("w1_sum", sum1, x ^ y);
        check_eq("w1_cout", cout1, x & y);
        tick();
        check_eq("w1_done_end", done1, 0);
        check_eq("w1_busy_idle", busy1, 0);
    endtask

    initial begin
        int done_cnt;
        int done_at[$];
        int bad_sum;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("rst_ovf", ovf, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_add(8'd3, 8'd5);
        run_add(8'd255, 8'd1);
        run_add(8'd127, 8'd1);
        run_add(8'd0, 8'd0);
        run_add(8'd255, 8'd255);
        run_add(8'd128, 8'd128);
        for (int i = 0; i < 25; i++) begin
            run_add(W'($urandom), W'($urandom));
        end

        // Start held high: a new operation is accepted only once the previous one has finished.
        done_cnt = 0;
        bad_sum  = 0;
        done_at.delete();
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || i == W + 2) begin
                a = 8'd1;
                b = 8'd1;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            if (done) begin
                done_cnt++;
                done_at.push_back(i);
                if (sum !== 8'd2 || cout !== 1'b0) bad_sum++;
            end
        end
        start = 1'b0;
        check_eq("held_done_count", done_cnt, 2);
        check_eq("held_bad_sums", bad_sum, 0);
        if (done_at.size() == 2) begin
            check_eq("held_first_done", done_at[0], W);
            check_eq("held_done_spacing", done_at[1] - done_at[0], W + 2);
        end
        exp_sum  = 8'd2;
        exp_cout = 1'b0;
        tick();
        check_eq("held_idle", busy, 0);

        // Reset in the middle of RUN aborts without a done pulse.
        a     = 8'd200;
        b     = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_sum", sum, 0);
        check_eq("abort_cout", cout, 0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);
        run_add(8'd200, 8'd100);
        check_eq("after_abort_sum", exp_sum, 8'd44);

        run_add1(1'b1, 1'b1);
        run_add1(1'b0, 1'b0);
        run_add1(1'b1, 1'b0);
        run_add1(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
